data_sram_responder: RTL

Memory-side responder for the CPU data port. It accepts the MEM-stage request (`mem_en`, `mem_we`, `sel`, address, write data) and serves it from an on-chip word-addressed SRAM after a fixed, parameterised latency. While the access is outstanding it drives `stallreq_from_mem` back into the hazard unit, then returns read data or commits the byte-lane write. It sits between the datapath data port and the system bus/BRAM level.

---
 rtl/data_sram_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Memory-side responder for the CPU data port. A MEM-stage request is
//   latched on acceptance and served from an on-chip word-addressed SRAM
//   after LATENCY cycles. While the access is outstanding the CPU is stalled.
//
// Ports:
//   clk               in  1   single clock, rising edge
//   rst               in  1   synchronous reset, active-low
//   mem_en            in  1   request valid (held by CPU while stalled)
//   mem_we            in  1   1 = write, 0 = read
//   mem_addr          in  32  byte address; word index = mem_addr[ADDR_W+1:2]
//   sel               in  4   byte-lane enables for writes
//   mem_wdata         in  32  lane-aligned write data
//   mem_rdata         out 32  registered read data (updated by reads only)
//   stallreq_from_mem out 1   CPU must hold the pipeline this cycle
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  sel,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        stallreq_from_mem
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [2:0] CNT_INIT = 3'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;
  logic                w_commit;

  logic                r_we;
  logic [ADDR_W-1:0]   r_idx;
  logic [3:0]          r_sel;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;

  logic [31:0]         r_ram [2**ADDR_W];

  logic                w_acc_we;
  logic [ADDR_W-1:0]   w_acc_idx;
  logic [3:0]          w_acc_sel;
  logic [31:0]         w_acc_wdata;
  logic                w_accept;
  logic                w_unused_addr;

  // Address bits outside the word index are intentionally ignored (aliasing).
  assign w_unused_addr = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  assign w_accept = (r_state == S_IDLE) && mem_en;

  // With LATENCY=1 the commit happens on the acceptance edge itself, before
  // the request has been latched, so the live inputs are used in IDLE.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_acc_we    = mem_we;
      w_acc_idx   = mem_addr[ADDR_W+1:2];
      w_acc_sel   = sel;
      w_acc_wdata = mem_wdata;
    end else begin
      w_acc_we    = r_we;
      w_acc_idx   = r_idx;
      w_acc_sel   = r_sel;
      w_acc_wdata = r_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_en) begin
          if (LATENCY == 1) begin
            w_state_nxt = S_DONE;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_BUSY: begin
        if (!mem_en) begin
          // Request withdrawn (flush/exception): abandon without side effects.
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 3'd0) begin
          w_state_nxt = S_DONE;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_rdata <= 32'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_sel   <= 4'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= mem_we;
        r_idx   <= mem_addr[ADDR_W+1:2];
        r_sel   <= sel;
        r_wdata <= mem_wdata;
      end
      if (w_commit && !w_acc_we) begin
        r_rdata <= r_ram[w_acc_idx];
      end
    end
  end

  // SRAM contents are never reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (rst && w_commit && w_acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_sel[i]) begin
          r_ram[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_rdata         = r_rdata;
  assign stallreq_from_mem = rst && mem_en && (r_state != S_DONE);

endmodule
